// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control-to-datapath bundle for the multicycle MIPS32 control FSM
interface multicycle_control_if;
    logic [5:0] i_op;
    logic       i_memReady;
    logic       o_pcWrite;
    logic       o_pcWriteCond;
    logic       o_iorD;
    logic       o_memRead;
    logic       o_memWrite;
    logic       o_irWrite;
    logic       o_memToReg;
    logic       o_regDst;
    logic       o_regWrite;
    logic       o_aluSrcA;
    logic [1:0] o_aluSrcB;
    logic [1:0] o_aluOp;
    logic [1:0] o_pcSrc;
    logic       o_illegal;
    logic [3:0] o_state;

    modport master (
        input  i_op, i_memReady,
        output o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite,
               o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_aluSrcB, o_aluOp,
               o_pcSrc, o_illegal, o_state
    );

    modport slave (
        output i_op, i_memReady,
        input  o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite,
               o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_aluSrcB, o_aluOp,
               o_pcSrc, o_illegal, o_state
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle MIPS32 datapath
module multicycle_control #(
    parameter bit WAIT_ENABLE = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    multicycle_control_if.master   bus
);

    typedef enum logic [3:0] {
        RESET   = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        RTYPEEX = 4'd7,
        RTYPEWB = 4'd8,
        BEQEX   = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JEX     = 4'd12,
        ILLEGAL = 4'd13
    } state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
        logic       illegal;
        logic       isFetch;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state;
    state_t stateNext;
    ctrl_t  ctrl;
    logic   ready;
    logic   fetchDone;

    assign ready = WAIT_ENABLE ? bus.i_memReady : 1'b1;

    function automatic state_t nextState(input state_t s, input logic [5:0] op, input logic rdy);
        case (s)
            RESET:   return FETCH;
            FETCH:   return rdy ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: return MEMADR;
                    OP_R:         return RTYPEEX;
                    OP_BEQ:       return BEQEX;
                    OP_ADDI:      return ADDIEX;
                    OP_J:         return JEX;
                    default:      return ILLEGAL;
                endcase
            end
            MEMADR:  return (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   return rdy ? MEMWB : MEMRD;
            MEMWB:   return FETCH;
            MEMWR:   return rdy ? FETCH : MEMWR;
            RTYPEEX: return RTYPEWB;
            RTYPEWB: return FETCH;
            BEQEX:   return FETCH;
            ADDIEX:  return ADDIWB;
            ADDIWB:  return FETCH;
            JEX:     return FETCH;
            ILLEGAL: return FETCH;
            default: return RESET;
        endcase
    endfunction

    // Outputs are decoded from the state being entered so they are registered with it.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:   begin c.memRead = 1'b1; c.aluSrcB = 2'b01; c.isFetch = 1'b1; end
            DECODE:  c.aluSrcB = 2'b11;
            MEMADR:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            MEMRD:   begin c.memRead = 1'b1; c.iorD = 1'b1; end
            MEMWB:   begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
            MEMWR:   begin c.memWrite = 1'b1; c.iorD = 1'b1; end
            RTYPEEX: begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
            RTYPEWB: begin c.regWrite = 1'b1; c.regDst = 1'b1; end
            BEQEX:   begin c.aluSrcA = 1'b1; c.aluOp = 2'b01; c.pcWriteCond = 1'b1; c.pcSrc = 2'b01; end
            ADDIEX:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            ADDIWB:  c.regWrite = 1'b1;
            JEX:     begin c.pcWrite = 1'b1; c.pcSrc = 2'b10; end
            ILLEGAL: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    assign stateNext = nextState(state, bus.i_op, ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RESET;
            ctrl  <= '0;
        end else begin
            state <= stateNext;
            ctrl  <= decode(stateNext);
        end
    end

    // IR and PC load only in the cycle the fetch read actually completes.
    assign fetchDone = ctrl.isFetch & ready;

    assign bus.o_pcWrite     = ctrl.pcWrite | fetchDone;
    assign bus.o_pcWriteCond = ctrl.pcWriteCond;
    assign bus.o_iorD        = ctrl.iorD;
    assign bus.o_memRead     = ctrl.memRead;
    assign bus.o_memWrite    = ctrl.memWrite;
    assign bus.o_irWrite     = fetchDone;
    assign bus.o_memToReg    = ctrl.memToReg;
    assign bus.o_regDst      = ctrl.regDst;
    assign bus.o_regWrite    = ctrl.regWrite;
    assign bus.o_aluSrcA     = ctrl.aluSrcA;
    assign bus.o_aluSrcB     = ctrl.aluSrcB;
    assign bus.o_aluOp       = ctrl.aluOp;
    assign bus.o_pcSrc       = ctrl.pcSrc;
    assign bus.o_illegal     = ctrl.illegal;
    assign bus.o_state       = state;

endmodule
